// File: rtl/ysyx_25040129_lsu_if.sv
// LSU bundle: EXU-side op handshake, write-back result handshake and the
// main-memory request/response channel with its latched operand bus.
interface ysyx_25040129_lsu_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_read;
  logic [1:0]  in_write;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;
  logic        is_req_valid;
  logic        is_req_ready;
  logic        is_rsp_valid;
  logic        is_rsp_ready;
  logic [2:0]  mmem_read;
  logic [1:0]  mmem_write;
  logic [31:0] mmem_addr;
  logic [31:0] mmem_write_data;
  logic [31:0] mmem_read_data;

  // LSU view
  modport master (
    input  in_valid,
    output in_ready,
    input  in_read,
    input  in_write,
    input  in_addr,
    input  in_wdata,
    output out_valid,
    input  out_ready,
    output out_rdata,
    output out_err,
    output is_req_valid,
    input  is_req_ready,
    input  is_rsp_valid,
    output is_rsp_ready,
    output mmem_read,
    output mmem_write,
    output mmem_addr,
    output mmem_write_data,
    input  mmem_read_data
  );

  // EXU / write-back / memory view
  modport slave (
    output in_valid,
    input  in_ready,
    output in_read,
    output in_write,
    output in_addr,
    output in_wdata,
    input  out_valid,
    output out_ready,
    input  out_rdata,
    input  out_err,
    input  is_req_valid,
    output is_req_ready,
    output is_rsp_valid,
    input  is_rsp_ready,
    input  mmem_read,
    input  mmem_write,
    input  mmem_addr,
    input  mmem_write_data,
    output mmem_read_data
  );
endinterface

// File: rtl/ysyx_25040129_lsu.sv
// Load/store unit: one outstanding op, IDLE->REQ->WAIT->DONE handshake FSM.
// Ports: clk, rst (sync, active-high), bus (ysyx_25040129_lsu_if.master).
// Macro YSYX_25040129_LSU_MISALIGN_EN enables the alignment check / out_err.
module ysyx_25040129_lsu (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_25040129_lsu_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t      state;
  state_t      state_n;

  logic [2:0]  rd_q;
  logic [2:0]  rd_n;
  logic [1:0]  wr_q;
  logic [1:0]  wr_n;
  logic [31:0] addr_q;
  logic [31:0] addr_n;
  logic [31:0] wdata_q;
  logic [31:0] wdata_n;
  logic [31:0] rdata_q;
  logic [31:0] rdata_n;
  logic        err_q;
  logic        err_n;

  logic        has_rd;
  logic        has_wr;
  logic        misal;

  assign has_rd = |bus.in_read;
  assign has_wr = |bus.in_write;

`ifdef YSYX_25040129_LSU_MISALIGN_EN
  logic is_half;
  logic is_word;

  // Size follows the effective op: a load wins over a store.
  always_comb begin
    is_half = 1'b0;
    is_word = 1'b0;
    if (has_rd) begin
      is_half = (bus.in_read == 3'd2) |
                (bus.in_read == 3'd5);
      is_word = (bus.in_read == 3'd3);
    end else begin
      is_half = (bus.in_write == 2'd2);
      is_word = (bus.in_write == 2'd3);
    end
  end

  assign misal = (is_half & bus.in_addr[0]) |
                 (is_word & (|bus.in_addr[1:0]));
`else
  assign misal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_q    <= 3'd0;
      wr_q    <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      rd_q    <= rd_n;
      wr_q    <= wr_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      rdata_q <= rdata_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    rd_n    = rd_q;
    wr_n    = wr_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    rdata_n = rdata_q;
    err_n   = err_q;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          rd_n    = bus.in_read;
          wr_n    = has_rd ? 2'd0 : bus.in_write;
          addr_n  = bus.in_addr;
          wdata_n = bus.in_wdata;
          rdata_n = 32'd0;
          if (misal) begin
            err_n   = 1'b1;
            state_n = DONE;
          end else if (has_rd | has_wr) begin
            err_n   = 1'b0;
            state_n = REQ;
          end else begin
            err_n   = 1'b0;
            state_n = DONE;
          end
        end
      end
      REQ: begin
        if (bus.is_req_ready) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (bus.is_rsp_valid) begin
          rdata_n = (|rd_q) ? bus.mmem_read_data
                            : 32'd0;
          state_n = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          rdata_n = 32'd0;
          err_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Moore outputs: decoded from state only.
  assign bus.in_ready        = (state == IDLE);
  assign bus.is_req_valid    = (state == REQ);
  assign bus.is_rsp_ready    = (state == WAIT);
  assign bus.out_valid       = (state == DONE);
  assign bus.out_rdata       = rdata_q;
  assign bus.out_err         = err_q;
  assign bus.mmem_read       = rd_q;
  assign bus.mmem_write      = wr_q;
  assign bus.mmem_addr       = addr_q;
  assign bus.mmem_write_data = wdata_q;

endmodule

// File: tb/tb_ysyx_25040129_lsu.sv
// Testbench for ysyx_25040129_lsu: directed plan plus randomized ops
// against a cycle-level expectation built from the op semantics.
module tb_ysyx_25040129_lsu;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail = 0;

  ysyx_25040129_lsu_if bus();

  ysyx_25040129_lsu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Access size in bytes of the effective op; misaligned if the address
  // is not a multiple of it (only when the check is built in).
  function automatic logic misaligned(input logic [2:0] rd,
                                      input logic [1:0] wr,
                                      input logic [31:0] a);
    int   bytes;
    logic en;
    if (rd == 3'd2 || rd == 3'd5) bytes = 2;
    else if (rd == 3'd3) bytes = 4;
    else if (rd != 3'd0) bytes = 1;
    else if (wr == 2'd2) bytes = 2;
    else if (wr == 2'd3) bytes = 4;
    else bytes = 1;
`ifdef YSYX_25040129_LSU_MISALIGN_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    return en && ((a % 32'(bytes)) != 32'd0);
  endfunction

  task automatic idle_inputs();
    bus.in_valid       = 1'b0;
    bus.in_read        = 3'($urandom_range(0, 7));
    bus.in_write       = 2'($urandom_range(0, 3));
    bus.in_addr        = $urandom;
    bus.in_wdata       = $urandom;
    bus.out_ready      = 1'b0;
    bus.is_req_ready   = 1'b0;
    bus.is_rsp_valid   = 1'b0;
    bus.mmem_read_data = $urandom;
  endtask

  task automatic run_op(input logic [2:0] rd,
                        input logic [1:0] wr,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [31:0] md,
                        input int rqs,
                        input int rss,
                        input int os);
    logic        bad;
    logic        mem;
    logic [1:0]  exp_wr;
    logic [31:0] exp_rd;
    bad    = misaligned(rd, wr, a);
    mem    = !bad && (rd != 3'd0 || wr != 2'd0);
    exp_wr = (rd != 3'd0) ? 2'd0 : wr;
    exp_rd = (mem && rd != 3'd0) ? md : 32'd0;

    bus.in_valid = 1'b1;
    bus.in_read  = rd;
    bus.in_write = wr;
    bus.in_addr  = a;
    bus.in_wdata = wd;
    @(negedge clk);
    chk("accept_in_ready", bus.in_ready, 1);
    cyc();
    idle_inputs();

    if (mem) begin
      for (int k = 0; k <= rqs; k++) begin
        bus.is_req_ready = (k == rqs);
        @(negedge clk);
        chk("req_valid", bus.is_req_valid, 1);
        chk("req_in_ready", bus.in_ready, 0);
        chk("req_out_valid", bus.out_valid, 0);
        chk("req_rsp_ready", bus.is_rsp_ready, 0);
        chk("mmem_read", bus.mmem_read, 32'(rd));
        chk("mmem_write", bus.mmem_write, 32'(exp_wr));
        chk("mmem_addr", bus.mmem_addr, a);
        chk("mmem_wdata", bus.mmem_write_data, wd);
        cyc();
      end
      bus.is_req_ready = 1'b0;
      for (int k = 0; k <= rss; k++) begin
        bus.is_rsp_valid   = (k == rss);
        bus.mmem_read_data = (k == rss) ? md : $urandom;
        @(negedge clk);
        chk("wait_rsp_ready", bus.is_rsp_ready, 1);
        chk("wait_req_valid", bus.is_req_valid, 0);
        chk("wait_out_valid", bus.out_valid, 0);
        cyc();
      end
      bus.is_rsp_valid   = 1'b0;
      bus.mmem_read_data = $urandom;
    end

    for (int k = 0; k <= os; k++) begin
      bus.out_ready = (k == os);
      @(negedge clk);
      chk("done_out_valid", bus.out_valid, 1);
      chk("done_rdata", bus.out_rdata, exp_rd);
      chk("done_err", bus.out_err, 32'(bad));
      chk("done_in_ready", bus.in_ready, 0);
      chk("done_req_valid", bus.is_req_valid, 0);
      chk("done_rsp_ready", bus.is_rsp_ready, 0);
      cyc();
    end
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("after_in_ready", bus.in_ready, 1);
    chk("after_out_valid", bus.out_valid, 0);
    chk("after_rdata", bus.out_rdata, 0);
    chk("after_err", bus.out_err, 0);
    cyc();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_err"}, bus.out_err, 0);
    chk({tag, "_req_valid"}, bus.is_req_valid, 0);
    chk({tag, "_rsp_ready"}, bus.is_rsp_ready, 0);
    chk({tag, "_rdata"}, bus.out_rdata, 0);
    chk({tag, "_mmem_read"}, bus.mmem_read, 0);
    chk({tag, "_mmem_write"}, bus.mmem_write, 0);
    chk({tag, "_mmem_addr"}, bus.mmem_addr, 0);
    chk({tag, "_mmem_wdata"}, bus.mmem_write_data, 0);
  endtask

  task automatic reset_in_wait();
    bus.in_valid = 1'b1;
    bus.in_read  = 3'd3;
    bus.in_write = 2'd0;
    bus.in_addr  = 32'h8000_0040;
    bus.in_wdata = 32'h0;
    @(negedge clk);
    chk("rw_in_ready", bus.in_ready, 1);
    cyc();
    idle_inputs();
    bus.is_req_ready = 1'b1;
    @(negedge clk);
    chk("rw_req_valid", bus.is_req_valid, 1);
    cyc();
    bus.is_req_ready = 1'b0;
    @(negedge clk);
    chk("rw_rsp_ready", bus.is_rsp_ready, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    reset_checks("rw");
    cyc();
  endtask

  initial begin
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic [31:0] a;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    reset_checks("rst");
    cyc();

    run_op(3'd3, 2'd0, 32'h8000_0010, 32'h0,
           32'hDEAD_BEEF, 0, 0, 0);
    run_op(3'd1, 2'd0, 32'h8000_0003, 32'h0,
           32'hFFFF_FF80, 2, 0, 0);
    run_op(3'd0, 2'd3, 32'h8000_0020, 32'h1234_5678,
           32'hCAFE_F00D, 4, 1, 0);
    run_op(3'd2, 2'd0, 32'h8000_0001, 32'h0,
           32'h0000_1234, 0, 0, 0);
    run_op(3'd0, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h5555_5555, 0, 0, 3);
    run_op(3'd3, 2'd3, 32'h8000_0008, 32'hAAAA_AAAA,
           32'h0BAD_CAFE, 1, 2, 1);
    run_op(3'd0, 2'd2, 32'h8000_0006, 32'h0000_BEEF,
           32'h7777_7777, 0, 0, 0);
    reset_in_wait();
    run_op(3'd3, 2'd0, 32'h8000_0044, 32'h0,
           32'h1357_9BDF, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      rd = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 5)) : 3'd0;
      wr = 2'($urandom_range(0, 3));
      a  = 32'h8000_0000 | ($urandom & 32'h0000_0FFC);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(0, 3));
      run_op(rd, wr, a, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
